// File: rtl/mux_nx1_stage.sv
// N-input, WIDTH-bit registered selector with a valid/ready output stage and flush.
// Define MUX_NX1_SEL_CHECK_EN to build the sticky out-of-range select checker (SEL_ERR).
module mux_nx1_stage #(
    parameter int WIDTH = 32,
    parameter int N_IN  = 3,
    localparam int SEL_W = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [N_IN*WIDTH-1:0] IN_BUS,
    input  logic [SEL_W-1:0]      SELECT,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic                  FLUSH,
    output logic [WIDTH-1:0]      OUT,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic                  SEL_ERR
);

    logic [WIDTH-1:0] outQ, outD;
    logic             outValidQ, outValidD;
    logic [WIDTH-1:0] selData;
    logic             accept;

    // Unmatched select codes fall through to input 0, like the legacy 3:1 mux.
    always_comb begin
        selData = IN_BUS[0 +: WIDTH];
        for (int k = 1; k < N_IN; k++) begin
            if (SELECT == SEL_W'(k)) begin
                selData = IN_BUS[k*WIDTH +: WIDTH];
            end
        end
    end

    assign IN_READY = !outValidQ || OUT_READY;
    assign accept   = IN_VALID && IN_READY && !FLUSH;

    always_comb begin
        outD      = outQ;
        outValidD = outValidQ;
        if (FLUSH) begin
            outValidD = 1'b0;
        end else if (accept) begin
            outD      = selData;
            outValidD = 1'b1;
        end else if (outValidQ && OUT_READY) begin
            outValidD = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            outQ      <= '0;
            outValidQ <= 1'b0;
        end else begin
            outQ      <= outD;
            outValidQ <= outValidD;
        end
    end

    assign OUT       = outQ;
    assign OUT_VALID = outValidQ;

`ifdef MUX_NX1_SEL_CHECK_EN
    logic selErrQ, selErrD;
    logic selOutOfRange;

    // A flush does not hide a bad select code; only the handshake qualifies it.
    assign selOutOfRange = int'(SELECT) >= N_IN;
    assign selErrD       = selErrQ || (IN_VALID && IN_READY && selOutOfRange);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            selErrQ <= 1'b0;
        end else begin
            selErrQ <= selErrD;
        end
    end

    assign SEL_ERR = selErrQ;
`else
    assign SEL_ERR = 1'b0;
`endif

endmodule
